chnlnk_frame_rcvr: RTL
======================

Name: chnlnk_frame_rcvr

Overview:
Receive end of the channel-link frame protocol. Consumes the word stream produced by the frame transmitter, which carries VALID, a 7-bit SEQ tag, a data word and a LAST_WRD strobe. Checks sequence continuity, frame length and a CRC-16 tail word. Writes sample words to a downstream buffer and reports per-frame and per-event status to the readout controller.

Parameters:
DW, 16, data word width; the CRC is computed over the low 16 bits.
NSAMP, 96, sample words per frame (SEQ 0..NSAMP-1).
NTAIL, 4, tail words per frame (SEQ NSAMP..NSAMP+NTAIL-1). The last tail word carries the CRC. NSAMP+NTAIL must be at most 128.

Ports:
CLK  in  1  system clock; sole clock.
RST_N  in  1  synchronous active-low reset.
VALID_IN  in  1  word strobe from the link.
SEQ_IN  in  7  word sequence tag; valid only when VALID_IN=1.
DIN  in  DW  link data word.
LAST_WRD_IN  in  1  end-of-event strobe; VALID_IN=0 in that cycle.
WE  out  1  sample write enable.
WADDR  out  7  sample address; equals the SEQ of the written word.
WDATA  out  DW  sample data.
FRM_DONE  out  1  one-cycle pulse when a frame terminates, whether completed or aborted.
FRM_ERR  out  1  qualifies FRM_DONE: high if the frame had any error.
SEQ_ERR  out  1  one-cycle pulse on a sequence violation.
TRUNC_ERR  out  1  one-cycle pulse when VALID_IN drops mid-frame.
CRC_ERR  out  1  one-cycle pulse, coincident with FRM_DONE, when the CRC mismatches.
EVT_DONE  out  1  one-cycle pulse when LAST_WRD_IN follows a good frame.
FRM_CNT  out  16  count of good frames; wraps at 2^16.

Behaviour:
- All outputs are registered. While RST_N=0 at a CLK edge, all outputs are 0, FRM_CNT=0 and the FSM goes to IDLE. Reset mid-frame discards the frame with no FRM_DONE.
- Let L = NSAMP+NTAIL-1, the last SEQ (99 at defaults). Let E = the expected SEQ counter (7 bits).
- Word latency: a word sampled at edge T produces WE/WADDR/WDATA in the cycle after T. Status pulses produced by that word appear in the same cycle.
- FSM states: IDLE, DATA, TAIL, POST.
  - IDLE:
    - VALID_IN=1 and SEQ_IN=0: accept the word, initialise the CRC to 0xFFFF and fold in DIN, set E=1, go to DATA.
    - VALID_IN=1 and SEQ_IN≠0: discard the word. Pulse SEQ_ERR once per run of consecutive discarded words, not once per word. Stay in IDLE.
  - DATA (E < NSAMP):
    - VALID_IN=1 and SEQ_IN=E: WE=1, update the CRC, E=E+1. Go to TAIL when E becomes NSAMP.
  - TAIL:
    - VALID_IN=1 and SEQ_IN=E<L: fold DIN into the CRC, no WE, E=E+1.
    - SEQ_IN=L: compare DIN[15:0] with the CRC register.
      - Pulse FRM_DONE. Set CRC_ERR and FRM_ERR equal to the mismatch result.
      - On a match, increment FRM_CNT.
      - Go to POST.
  - POST (one cycle):
    - LAST_WRD_IN=1 and the frame was good: pulse EVT_DONE.
    - Then behave as IDLE for the current input: VALID_IN=1 with SEQ_IN=0 starts a new frame back-to-back.
- Abort conditions in DATA or TAIL:
  - VALID_IN=0: pulse TRUNC_ERR, plus FRM_DONE with FRM_ERR=1. Go to IDLE.
  - VALID_IN=1 and SEQ_IN≠E: pulse SEQ_ERR, plus FRM_DONE with FRM_ERR=1.
    - If SEQ_IN=0 in the same cycle, the aborting word starts a new frame (the DATA entry actions apply).
    - Otherwise go to IDLE.
- Samples already written before an abort are not retracted. The consumer discards them based on FRM_ERR.
- LAST_WRD_IN in any state other than POST is ignored.
- CRC: CRC-16-CCITT, polynomial 0x1021, initial value 0xFFFF, 16 bits processed MSB first per word, no reflection, no final XOR. It covers words SEQ 0..L-1. Word L is compared and is not folded in.
- FRM_CNT increments only on good frames and wraps 0xFFFF→0x0000.

Optional Feature:
Macro CHNLNK_RX_ERRCNT_EN.
- Defined: adds output port ERR_CNT [15:0]. It increments once for each FRM_DONE with FRM_ERR=1, and once for each IDLE discard run. It saturates at 0xFFFF and resets to 0 on RST_N=0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Good frame: SEQ 0..99 back-to-back, DIN=SEQ, word 99 = CRC from the reference model, then LAST_WRD_IN. Expected: 96 WE pulses with WADDR 0..95, FRM_DONE=1 with FRM_ERR=0, EVT_DONE one cycle later, FRM_CNT=1.
- CRC error: same frame with word 99 XORed with 0x0001. Expected: FRM_DONE, CRC_ERR and FRM_ERR all 1; FRM_CNT unchanged; a following LAST_WRD_IN gives no EVT_DONE.
- Sequence skip: SEQ 0..40 then 42. Expected: SEQ_ERR and FRM_DONE/FRM_ERR in the cycle after SEQ 42 is sampled; state returns to IDLE; words 43.. are discarded with exactly one further SEQ_ERR pulse.
- Truncation: VALID_IN drops after SEQ 97. Expected: TRUNC_ERR=1, FRM_ERR=1, no CRC_ERR; the next SEQ 0 starts a clean frame.
- Restart on abort: SEQ 0..10 then SEQ 0..99 good. Expected: one aborted FRM_DONE, then one good FRM_DONE; FRM_CNT=1.
- Reset mid-frame: RST_N=0 for one cycle at SEQ 50. Expected: all outputs 0, no FRM_DONE, FRM_CNT=0; SEQ 51.. discarded with one SEQ_ERR pulse. With CHNLNK_RX_ERRCNT_EN defined, ERR_CNT=1 after that discard run.

Source files
------------

// File: rtl/chnlnk_frame_rcvr.sv
// Channel-link frame receiver: sequence, length and CRC-16 checks, sample write-out, frame/event status.
// Optional macro CHNLNK_RX_ERRCNT_EN adds a saturating error counter on port ERR_CNT.
module chnlnk_frame_rcvr #(
  parameter int DW    = 16,
  parameter int NSAMP = 96,
  parameter int NTAIL = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          VALID_IN,
  input  logic [6:0]    SEQ_IN,
  input  logic [DW-1:0] DIN,
  input  logic          LAST_WRD_IN,
  output logic          WE,
  output logic [6:0]    WADDR,
  output logic [DW-1:0] WDATA,
  output logic          FRM_DONE,
  output logic          FRM_ERR,
  output logic          SEQ_ERR,
  output logic          TRUNC_ERR,
  output logic          CRC_ERR,
  output logic          EVT_DONE,
  output logic [15:0]   FRM_CNT
`ifdef CHNLNK_RX_ERRCNT_EN
  ,
  output logic [15:0]   ERR_CNT
`endif
);

  localparam logic [6:0] LAST_SEQ  = 7'(NSAMP + NTAIL - 1);
  localparam logic [6:0] LAST_SAMP = 7'(NSAMP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL, ST_POST} state_t;

  // CRC-16-CCITT (0x1021), one 16-bit word folded in MSB first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_t        state_r, state_s;
  logic [6:0]    seq_exp_r, seq_exp_s;
  logic [15:0]   crc_r, crc_s, crc_start_s;
  logic          disc_r, disc_s;
  logic          good_r, good_s;
  logic          we_s, frm_done_s, frm_err_s, seq_err_s, trunc_s, crc_err_s, evt_s;
  logic [6:0]    waddr_s;
  logic [DW-1:0] wdata_s;
  logic [15:0]   cnt_s;

  // Next-state, datapath and status-pulse decode for the sampled link word.
  always_comb begin
    state_s     = state_r;
    seq_exp_s   = seq_exp_r;
    crc_s       = crc_r;
    disc_s      = disc_r;
    good_s      = good_r;
    we_s        = 1'b0;
    frm_done_s  = 1'b0;
    frm_err_s   = 1'b0;
    seq_err_s   = 1'b0;
    trunc_s     = 1'b0;
    crc_err_s   = 1'b0;
    evt_s       = 1'b0;
    cnt_s       = FRM_CNT;
    crc_start_s = crc16_upd(16'hFFFF, DIN[15:0]);
    case (state_r)
      ST_IDLE, ST_POST: begin
        evt_s   = (state_r == ST_POST) && LAST_WRD_IN && good_r;
        good_s  = 1'b0;
        state_s = ST_IDLE;
        if (VALID_IN && (SEQ_IN == 7'd0)) begin
          we_s      = 1'b1;
          crc_s     = crc_start_s;
          seq_exp_s = 7'd1;
          disc_s    = 1'b0;
          state_s   = (LAST_SAMP == 7'd0) ? ST_TAIL : ST_DATA;
        end else if (VALID_IN) begin
          // only the first word of a run of discards is reported
          seq_err_s = ~disc_r;
          disc_s    = 1'b1;
        end else begin
          disc_s    = 1'b0;
        end
      end
      ST_DATA, ST_TAIL: begin
        disc_s = 1'b0;
        if (!VALID_IN) begin
          trunc_s    = 1'b1;
          frm_done_s = 1'b1;
          frm_err_s  = 1'b1;
          state_s    = ST_IDLE;
        end else if (SEQ_IN != seq_exp_r) begin
          seq_err_s  = 1'b1;
          frm_done_s = 1'b1;
          frm_err_s  = 1'b1;
          // expected SEQ is never 0 here, so a SEQ 0 word always restarts
          if (SEQ_IN == 7'd0) begin
            we_s      = 1'b1;
            crc_s     = crc_start_s;
            seq_exp_s = 7'd1;
            state_s   = (LAST_SAMP == 7'd0) ? ST_TAIL : ST_DATA;
          end else begin
            state_s   = ST_IDLE;
          end
        end else if (state_r == ST_DATA) begin
          we_s      = 1'b1;
          crc_s     = crc16_upd(crc_r, DIN[15:0]);
          seq_exp_s = seq_exp_r + 7'd1;
          state_s   = (seq_exp_r == LAST_SAMP) ? ST_TAIL : ST_DATA;
        end else if (seq_exp_r == LAST_SEQ) begin
          frm_done_s = 1'b1;
          crc_err_s  = (DIN[15:0] != crc_r);
          frm_err_s  = crc_err_s;
          good_s     = ~crc_err_s;
          cnt_s      = crc_err_s ? FRM_CNT : FRM_CNT + 16'd1;
          state_s    = ST_POST;
        end else begin
          crc_s     = crc16_upd(crc_r, DIN[15:0]);
          seq_exp_s = seq_exp_r + 7'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    waddr_s = we_s ? SEQ_IN : 7'd0;
    wdata_s = we_s ? DIN : {DW{1'b0}};
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      seq_exp_r <= 7'd0;
      crc_r     <= 16'hFFFF;
      disc_r    <= 1'b0;
      good_r    <= 1'b0;
      WE        <= 1'b0;
      WADDR     <= 7'd0;
      WDATA     <= {DW{1'b0}};
      FRM_DONE  <= 1'b0;
      FRM_ERR   <= 1'b0;
      SEQ_ERR   <= 1'b0;
      TRUNC_ERR <= 1'b0;
      CRC_ERR   <= 1'b0;
      EVT_DONE  <= 1'b0;
      FRM_CNT   <= 16'd0;
    end else begin
      state_r   <= state_s;
      seq_exp_r <= seq_exp_s;
      crc_r     <= crc_s;
      disc_r    <= disc_s;
      good_r    <= good_s;
      WE        <= we_s;
      WADDR     <= waddr_s;
      WDATA     <= wdata_s;
      FRM_DONE  <= frm_done_s;
      FRM_ERR   <= frm_err_s;
      SEQ_ERR   <= seq_err_s;
      TRUNC_ERR <= trunc_s;
      CRC_ERR   <= crc_err_s;
      EVT_DONE  <= evt_s;
      FRM_CNT   <= cnt_s;
    end
  end

`ifdef CHNLNK_RX_ERRCNT_EN
  logic err_inc_s;
  // a SEQ_ERR without FRM_DONE is exactly the start of an idle discard run
  assign err_inc_s = (frm_done_s & frm_err_s) | (seq_err_s & ~frm_done_s);

  // Saturating count of errored frames and discard runs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ERR_CNT <= 16'd0;
    end else if (err_inc_s && (ERR_CNT != 16'hFFFF)) begin
      ERR_CNT <= ERR_CNT + 16'd1;
    end else begin
      ERR_CNT <= ERR_CNT;
    end
  end
`endif

endmodule
